// File: rtl/chiplib_pri_queue_pkg.sv
// Shared types for the priority shift queue: pop ordering and per-slot update operation.
package chiplib_pri_queue_pkg;

  typedef enum logic {
    PriMaxFirst,
    PriMinFirst
  } pri_order_e;

  typedef enum logic [1:0] {
    OpHold,
    OpShiftUp,
    OpShiftDown,
    OpLoadNew
  } slot_op_e;

endpackage

// File: rtl/chiplib_pri_queue_slot.sv
// One entry of the sorted shift queue: entry register, "new beats me" comparator and update mux.
module chiplib_pri_queue_slot
  import chiplib_pri_queue_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PriorityWidth = 16,
  parameter pri_order_e  Order         = PriMaxFirst
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  slot_op_e                 op_i,
  input  logic [PriorityWidth-1:0] new_pri_i,
  input  logic [DataWidth-1:0]     new_data_i,
  input  logic                     up_valid_i,
  input  logic [PriorityWidth-1:0] up_pri_i,
  input  logic [DataWidth-1:0]     up_data_i,
  input  logic                     dn_valid_i,
  input  logic [PriorityWidth-1:0] dn_pri_i,
  input  logic [DataWidth-1:0]     dn_data_i,
  output logic                     valid_o,
  output logic [PriorityWidth-1:0] pri_o,
  output logic [DataWidth-1:0]     data_o,
  output logic                     beats_o
);

  logic                     valid_q, valid_d;
  logic [PriorityWidth-1:0] pri_q, pri_d;
  logic [DataWidth-1:0]     data_q, data_d;

  // An empty slot is always a legal insertion point; equal priorities never beat.
  assign beats_o = !valid_q ? 1'b1 :
                   (Order == PriMaxFirst) ? (new_pri_i > pri_q) : (new_pri_i < pri_q);

  always_comb begin
    valid_d = valid_q;
    pri_d   = pri_q;
    data_d  = data_q;
    unique case (op_i)
      OpHold: begin
      end
      OpShiftUp: begin
        valid_d = up_valid_i;
        pri_d   = up_pri_i;
        data_d  = up_data_i;
      end
      OpShiftDown: begin
        valid_d = dn_valid_i;
        pri_d   = dn_pri_i;
        data_d  = dn_data_i;
      end
      OpLoadNew: begin
        valid_d = 1'b1;
        pri_d   = new_pri_i;
        data_d  = new_data_i;
      end
      default: begin
      end
    endcase
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    pri_q  <= pri_d;
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign pri_o   = pri_q;
  assign data_o  = data_q;

endmodule

// File: rtl/chiplib_pri_shift_queue.sv
// Sorted shift-register priority queue; head entry (slot 0) drives the pop interface from flops.
module chiplib_pri_shift_queue
  import chiplib_pri_queue_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PriorityWidth = 16,
  parameter int unsigned QueueDepth    = 16,
  parameter pri_order_e  Order         = PriMaxFirst
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DataWidth-1:0]             push_data,
  input  logic [PriorityWidth-1:0]         push_pri,
  input  logic                             push_valid,
  output logic                             push_ready,
  output logic [DataWidth-1:0]             pop_data,
  output logic [PriorityWidth-1:0]         pop_pri,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  input  logic                             flush,
  output logic [$clog2(QueueDepth+1)-1:0]  count
);

  localparam int unsigned CountWidth = $clog2(QueueDepth + 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(QueueDepth);

  logic [QueueDepth-1:0]    valid;
  logic [QueueDepth-1:0]    beats;
  logic [QueueDepth-1:0]    ins_push;
  logic [QueueDepth-1:0]    beats_post;
  logic [QueueDepth-1:0]    ins_post;
  logic [PriorityWidth-1:0] pri  [QueueDepth];
  logic [DataWidth-1:0]     data [QueueDepth];
  slot_op_e                 op   [QueueDepth];

  logic                  push_fire, pop_fire;
  logic [CountWidth-1:0] count_q;

  assign push_ready = (count_q != FullCount);
  assign pop_valid  = valid[0];
  assign pop_pri    = pri[0];
  assign pop_data   = data[0];
  assign count      = count_q;

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;

  // beats is a thermometer (0..0 1..1) because the array is sorted; its rising edge is the
  // insertion point. After a pop, slot i holds old slot i+1, so shift the thermometer by one.
  assign ins_push   = beats & ~{beats[QueueDepth-2:0], 1'b0};
  assign beats_post = {1'b1, beats[QueueDepth-1:1]};
  assign ins_post   = beats_post & ~{beats_post[QueueDepth-2:0], 1'b0};

  always_comb begin
    for (int i = 0; i < QueueDepth; i++) begin
      op[i] = OpHold;
      unique case ({push_fire, pop_fire})
        2'b10:   op[i] = ins_push[i] ? OpLoadNew : (beats[i] ? OpShiftDown : OpHold);
        2'b01:   op[i] = OpShiftUp;
        2'b11:   op[i] = ins_post[i] ? OpLoadNew : (beats_post[i] ? OpHold : OpShiftUp);
        default: op[i] = OpHold;
      endcase
    end
  end

  for (genvar i = 0; i < QueueDepth; i++) begin : g_slot
    logic                     up_valid, dn_valid;
    logic [PriorityWidth-1:0] up_pri, dn_pri;
    logic [DataWidth-1:0]     up_data, dn_data;

    if (i == QueueDepth - 1) begin : g_tail
      assign up_valid = 1'b0;
      assign up_pri   = '0;
      assign up_data  = '0;
    end else begin : g_body
      assign up_valid = valid[i+1];
      assign up_pri   = pri[i+1];
      assign up_data  = data[i+1];
    end

    if (i == 0) begin : g_head
      assign dn_valid = 1'b0;
      assign dn_pri   = '0;
      assign dn_data  = '0;
    end else begin : g_rest
      assign dn_valid = valid[i-1];
      assign dn_pri   = pri[i-1];
      assign dn_data  = data[i-1];
    end

    chiplib_pri_queue_slot #(
      .DataWidth    (DataWidth),
      .PriorityWidth(PriorityWidth),
      .Order        (Order)
    ) u_slot (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_i   (flush),
      .op_i      (op[i]),
      .new_pri_i (push_pri),
      .new_data_i(push_data),
      .up_valid_i(up_valid),
      .up_pri_i  (up_pri),
      .up_data_i (up_data),
      .dn_valid_i(dn_valid),
      .dn_pri_i  (dn_pri),
      .dn_data_i (dn_data),
      .valid_o   (valid[i]),
      .pri_o     (pri[i]),
      .data_o    (data[i]),
      .beats_o   (beats[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (push_fire && !pop_fire) begin
      count_q <= count_q + CountWidth'(1);
    end else if (pop_fire && !push_fire) begin
      count_q <= count_q - CountWidth'(1);
    end
  end

endmodule

// File: tb/tb_chiplib_pri_shift_queue.sv
// Directed bench for the priority shift queue: a max-first and a min-first instance share stimulus.
module tb_chiplib_pri_shift_queue;
  import chiplib_pri_queue_pkg::*;

  localparam int unsigned Dw = 16;
  localparam int unsigned Pw = 8;
  localparam int unsigned Qd = 4;
  localparam int unsigned Cw = $clog2(Qd + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [Dw-1:0] push_data = '0;
  logic [Pw-1:0] push_pri = '0;
  logic          push_valid = 1'b0;
  logic          pop_ready = 1'b0;
  logic          flush = 1'b0;

  logic          mx_push_ready, mx_pop_valid, mn_push_ready, mn_pop_valid;
  logic [Dw-1:0] mx_pop_data, mn_pop_data;
  logic [Pw-1:0] mx_pop_pri, mn_pop_pri;
  logic [Cw-1:0] mx_count, mn_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chiplib_pri_shift_queue #(
    .DataWidth(Dw), .PriorityWidth(Pw), .QueueDepth(Qd), .Order(PriMaxFirst)
  ) u_max (
    .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_pri(push_pri),
    .push_valid(push_valid), .push_ready(mx_push_ready), .pop_data(mx_pop_data),
    .pop_pri(mx_pop_pri), .pop_valid(mx_pop_valid), .pop_ready(pop_ready),
    .flush(flush), .count(mx_count)
  );

  chiplib_pri_shift_queue #(
    .DataWidth(Dw), .PriorityWidth(Pw), .QueueDepth(Qd), .Order(PriMinFirst)
  ) u_min (
    .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_pri(push_pri),
    .push_valid(push_valid), .push_ready(mn_push_ready), .pop_data(mn_pop_data),
    .pop_pri(mn_pop_pri), .pop_valid(mn_pop_valid), .pop_ready(pop_ready),
    .flush(flush), .count(mn_count)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [Pw-1:0] p, input logic [Dw-1:0] d);
    push_valid = 1'b1;
    push_pri   = p;
    push_data  = d;
    cycle();
    push_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (mx_count !== 0 || mx_pop_valid !== 1'b0 || mx_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: count=%0d pop_valid=%b push_ready=%b, expected 0/0/1",
               mx_count, mx_pop_valid, mx_push_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_order();
    logic [Pw-1:0] mx_exp [4];
    logic [Pw-1:0] mn_exp [4];
    mx_exp = '{8'd9, 8'd7, 8'd5, 8'd1};
    mn_exp = '{8'd1, 8'd5, 8'd7, 8'd9};
    push1(8'd5, 16'h0005);
    push1(8'd9, 16'h0009);
    push1(8'd1, 16'h0001);
    push1(8'd7, 16'h0007);
    checks++;
    if (mx_count !== 4 || mn_count !== 4) begin
      errors++;
      $display("FAIL order_fill_count: max=%0d min=%0d, expected 4", mx_count, mn_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mx_pop_valid !== 1'b1 || mx_pop_pri !== mx_exp[i] || mx_pop_data !== {8'h00, mx_exp[i]})
      begin
        errors++;
        $display("FAIL max_pop%0d: valid=%b pri=%0d data=%h, expected 1/%0d", i, mx_pop_valid,
                 mx_pop_pri, mx_pop_data, mx_exp[i]);
      end
      checks++;
      if (mn_pop_valid !== 1'b1 || mn_pop_pri !== mn_exp[i]) begin
        errors++;
        $display("FAIL min_pop%0d: valid=%b pri=%0d, expected 1/%0d", i, mn_pop_valid,
                 mn_pop_pri, mn_exp[i]);
      end
      pop_ready = 1'b1;
      cycle();
      pop_ready = 1'b0;
      checks++;
      if (mx_count !== Cw'(3 - i)) begin
        errors++;
        $display("FAIL order_count%0d: got %0d, expected %0d", i, mx_count, 3 - i);
      end
    end
    checks++;
    if (mx_pop_valid !== 1'b0 || mn_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_empty: max valid=%b min valid=%b, expected 0", mx_pop_valid,
               mn_pop_valid);
    end
  endtask

  task automatic test_latency();
    push_valid = 1'b1;
    push_pri   = 8'd42;
    push_data  = 16'hbeef;
    #1;
    checks++;
    if (mx_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: pop_valid=%b before edge, expected 0", mx_pop_valid);
    end
    cycle();
    push_valid = 1'b0;
    checks++;
    if (mx_pop_valid !== 1'b1 || mx_pop_pri !== 8'd42 || mx_pop_data !== 16'hbeef) begin
      errors++;
      $display("FAIL latency1: valid=%b pri=%0d data=%h, expected 1/42/beef", mx_pop_valid,
               mx_pop_pri, mx_pop_data);
    end
    do_flush();
  endtask

  task automatic test_fifo_ties();
    logic [Dw-1:0] exp_d [3];
    exp_d = '{16'h000a, 16'h000b, 16'h000c};
    push1(8'd3, 16'h000a);
    push1(8'd3, 16'h000b);
    push1(8'd3, 16'h000c);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mx_pop_valid !== 1'b1 || mx_pop_data !== exp_d[i]) begin
        errors++;
        $display("FAIL tie_pop%0d: valid=%b data=%h, expected 1/%h", i, mx_pop_valid,
                 mx_pop_data, exp_d[i]);
      end
      pop_ready = 1'b1;
      cycle();
      pop_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    push1(8'd10, 16'h0010);
    push1(8'd20, 16'h0020);
    push1(8'd30, 16'h0030);
    push1(8'd40, 16'h0040);
    checks++;
    if (mx_push_ready !== 1'b0 || mx_count !== 4) begin
      errors++;
      $display("FAIL full_ready: push_ready=%b count=%0d, expected 0/4", mx_push_ready, mx_count);
    end
    push_valid = 1'b1;
    push_pri   = 8'd99;
    push_data  = 16'h0099;
    cycle();
    cycle();
    checks++;
    if (mx_count !== 4 || mx_pop_pri !== 8'd40) begin
      errors++;
      $display("FAIL full_reject: count=%0d head=%0d, expected 4/40", mx_count, mx_pop_pri);
    end
    pop_ready = 1'b1;
    cycle();
    pop_ready  = 1'b0;
    push_valid = 1'b0;
    checks++;
    if (mx_count !== 3 || mx_pop_pri !== 8'd30 || mx_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d head=%0d ready=%b, expected 3/30/1", mx_count,
               mx_pop_pri, mx_push_ready);
    end
    do_flush();
  endtask

  task automatic test_back_to_back();
    logic [Pw-1:0] exp_p [3];
    exp_p = '{8'd6, 8'd4, 8'd2};
    push1(8'd8, 16'h0008);
    push1(8'd4, 16'h0004);
    push1(8'd2, 16'h0002);
    push_valid = 1'b1;
    push_pri   = 8'd6;
    push_data  = 16'h0006;
    pop_ready  = 1'b1;
    #1;
    checks++;
    if (mx_pop_pri !== 8'd8 || mx_pop_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_popped: pri=%0d valid=%b, expected 8/1", mx_pop_pri, mx_pop_valid);
    end
    cycle();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    checks++;
    if (mx_count !== 3) begin
      errors++;
      $display("FAIL simul_count: got %0d, expected 3", mx_count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mx_pop_valid !== 1'b1 || mx_pop_pri !== exp_p[i]) begin
        errors++;
        $display("FAIL simul_pop%0d: valid=%b pri=%0d, expected 1/%0d", i, mx_pop_valid,
                 mx_pop_pri, exp_p[i]);
      end
      pop_ready = 1'b1;
      cycle();
      pop_ready = 1'b0;
    end
    pop_ready = 1'b1;
    cycle();
    pop_ready = 1'b0;
    checks++;
    if (mx_count !== 0 || mx_pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop: count=%0d valid=%b, expected 0/0", mx_count, mx_pop_valid);
    end
  endtask

  task automatic test_flush();
    push1(8'd1, 16'h0001);
    push1(8'd2, 16'h0002);
    push1(8'd3, 16'h0003);
    push1(8'd4, 16'h0004);
    flush      = 1'b1;
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    push_pri   = 8'd50;
    cycle();
    flush      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    checks++;
    if (mx_count !== 0 || mx_pop_valid !== 1'b0 || mx_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, expected 0/0/1", mx_count,
               mx_pop_valid, mx_push_ready);
    end
    push1(8'd7, 16'h0007);
    checks++;
    if (mx_count !== 1 || mx_pop_pri !== 8'd7) begin
      errors++;
      $display("FAIL post_flush: count=%0d head=%0d, expected 1/7", mx_count, mx_pop_pri);
    end
    do_flush();
  endtask

  task automatic test_reset_mid();
    push1(8'd11, 16'h0011);
    push1(8'd12, 16'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mx_count !== 0 || mx_pop_valid !== 1'b0 || mx_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b ready=%b, expected 0/0/1", mx_count,
               mx_pop_valid, mx_push_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    push1(8'd5, 16'h0005);
    checks++;
    if (mx_count !== 1 || mx_pop_pri !== 8'd5 || mx_pop_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: count=%0d head=%0d valid=%b, expected 1/5/1", mx_count,
               mx_pop_pri, mx_pop_valid);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_latency();
    test_fifo_ties();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
